combo_lock_ctrl: RTL and testbench

Sequencing controller for the board's combination lock. It accepts digit entries (0-9) one at a time, compares a four-digit entry against the stored code, and runs a timed unlock window. After repeated failures it runs a timed lockout. It also drives the progress LEDs and exposes a BCD countdown for the existing seven-segment decoder, all from a single `CLOCK_50` domain.

---
 rtl/combo_lock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_ctrl.sv
// rtl/combo_lock_ctrl.sv - four-digit combination lock sequencer with timed open window and failure lockout
// Define COMBO_LOCK_PROG_EN to build the PROG state that lets an opened lock take a new code.
module combo_lock_ctrl #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned UNLOCK_SECS  = 9,
  parameter int unsigned LOCKOUT_SECS = 9,
  parameter int unsigned MAX_FAIL     = 3,
  parameter logic [15:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       locked_out,
  output logic [3:0] progress,
  output logic [3:0] count_bcd,
  output logic [1:0] fail_cnt
);

  localparam int unsigned      PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0]       UNLOCK_LD  = 4'(UNLOCK_SECS);
  localparam logic [3:0]       LOCKOUT_LD = 4'(LOCKOUT_SECS);
  localparam logic [1:0]       FAIL_SAT   = 2'(MAX_FAIL);
  localparam logic [1:0]       FAIL_LAST  = 2'(MAX_FAIL - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT, S_PROG
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   code_q, code_d;
  logic [15:0]   entry_q, entry_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    progress_q, progress_d;
  logic [1:0]    fail_q, fail_d;
  logic          unlocked_q, unlocked_d;
  logic          locked_q, locked_d;
  logic          tick;
  logic          digit_ok;

  assign tick     = (presc_q == TICK_LAST);
  // clear takes priority over a coincident digit strobe
  assign digit_ok = digit_valid && (digit <= 4'd9) && !clear;

`ifndef COMBO_LOCK_PROG_EN
  logic unused_prog_req;
  assign unused_prog_req = prog_req;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      code_q     <= DEFAULT_CODE;
      entry_q    <= '0;
      idx_q      <= '0;
      presc_q    <= '0;
      count_q    <= '0;
      progress_q <= '0;
      fail_q     <= '0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      entry_q    <= entry_d;
      idx_q      <= idx_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      progress_q <= progress_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    entry_d    = entry_q;
    idx_d      = idx_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    count_d    = count_q;
    progress_d = progress_q;
    fail_d     = fail_q;
    unlocked_d = unlocked_q;
    locked_d   = locked_q;

    case (state_q)
      S_IDLE: begin
        if (digit_ok) begin
          entry_d    = {entry_q[11:0], digit};
          idx_d      = 2'd1;
          progress_d = 4'b0001;
          state_d    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (clear) begin
          idx_d      = '0;
          progress_d = '0;
          state_d    = S_IDLE;
        end else if (digit_ok) begin
          entry_d    = {entry_q[11:0], digit};
          progress_d = {progress_q[2:0], 1'b1};
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        progress_d = '0;
        presc_d    = '0;
        if (entry_q == code_q) begin
          fail_d     = '0;
          count_d    = UNLOCK_LD;
          progress_d = 4'b1111;
          unlocked_d = 1'b1;
          state_d    = S_OPEN;
        end else if (fail_q >= FAIL_LAST) begin
          fail_d   = FAIL_SAT;
          count_d  = LOCKOUT_LD;
          locked_d = 1'b1;
          state_d  = S_LOCKOUT;
        end else begin
          fail_d  = fail_q + 2'd1;
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (clear) begin
          count_d    = '0;
          progress_d = '0;
          unlocked_d = 1'b0;
          state_d    = S_IDLE;
`ifdef COMBO_LOCK_PROG_EN
        end else if (prog_req) begin
          count_d    = '0;
          progress_d = '0;
          idx_d      = '0;
          unlocked_d = 1'b0;
          state_d    = S_PROG;
`endif
        end else if (tick) begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            progress_d = '0;
            unlocked_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        if (tick) begin
          count_d = count_q - 4'd1;
          if (count_q == 4'd1) begin
            fail_d   = '0;
            locked_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
`ifdef COMBO_LOCK_PROG_EN
      S_PROG: begin
        if (clear) begin
          idx_d      = '0;
          progress_d = '0;
          state_d    = S_IDLE;
        end else if (digit_ok) begin
          entry_d    = {entry_q[11:0], digit};
          progress_d = {progress_q[2:0], 1'b1};
          idx_d      = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            code_d     = {entry_q[11:0], digit};
            progress_d = '0;
            state_d    = S_IDLE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign progress   = progress_q;
  assign count_bcd  = count_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb/tb_combo_lock_ctrl.sv - directed self-checking bench for combo_lock_ctrl
// Scenario tasks run in sequence from one initial block; prog test follows COMBO_LOCK_PROG_EN.
module tb_combo_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit;
  logic       digit_valid;
  logic       clear;
  logic       prog_req;
  logic       unlocked;
  logic       locked_out;
  logic [3:0] progress;
  logic [3:0] count_bcd;
  logic [1:0] fail_cnt;

  int total = 0;
  int bad   = 0;

  combo_lock_ctrl #(
    .TICK_DIV(4), .UNLOCK_SECS(3), .LOCKOUT_SECS(2), .MAX_FAIL(3), .DEFAULT_CODE(16'h1234)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .digit(digit), .digit_valid(digit_valid),
    .clear(clear), .prog_req(prog_req), .unlocked(unlocked), .locked_out(locked_out),
    .progress(progress), .count_bcd(count_bcd), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge after the strobe was sampled.
  task automatic enter_digit(input logic [3:0] d);
    @(negedge clk);
    digit = d; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) enter_digit(c[(3-i)*4 +: 4]);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; digit = '0; digit_valid = 1'b0; clear = 1'b0; prog_req = 1'b0;
    repeat (2) @(negedge clk);
    total++; if ({unlocked, locked_out, progress, count_bcd, fail_cnt} !== 12'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 000", {unlocked, locked_out, progress, count_bcd, fail_cnt});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct_code;
    logic [3:0] exp_cnt;
    enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
    total++; if (progress !== 4'b0111) begin
      bad++; $display("FAIL progress_three: got %b want 0111", progress);
    end
    enter_digit(4'd4);
    total++; if (unlocked !== 1'b0) begin
      bad++; $display("FAIL check_not_open_yet: got %b want 0", unlocked);
    end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp_cnt = (i < 4) ? 4'd3 : (i < 8) ? 4'd2 : (i < 12) ? 4'd1 : 4'd0;
      total++; if (count_bcd !== exp_cnt || unlocked !== (i < 12)) begin
        bad++; $display("FAIL open_countdown[%0d]: got cnt=%0d unl=%b want cnt=%0d unl=%b", i, count_bcd, unlocked, exp_cnt, (i < 12));
      end
    end
    total++; if (progress !== 4'b0000) begin
      bad++; $display("FAIL progress_after_timeout: got %b want 0000", progress);
    end
  endtask

  task automatic test_three_failures;
    logic [3:0] exp_cnt;
    for (int k = 1; k <= 2; k++) begin
      enter_code(16'h1235);
      @(negedge clk);
      total++; if (fail_cnt !== 2'(k) || unlocked !== 1'b0 || progress !== 4'b0) begin
        bad++; $display("FAIL fail_count_%0d: got fc=%0d unl=%b prog=%b want fc=%0d unl=0 prog=0000", k, fail_cnt, unlocked, progress, k);
      end
    end
    enter_code(16'h1235);
    @(negedge clk);
    total++; if (locked_out !== 1'b1 || fail_cnt !== 2'd3 || count_bcd !== 4'd2) begin
      bad++; $display("FAIL lockout_entry: got lo=%b fc=%0d cnt=%0d want lo=1 fc=3 cnt=2", locked_out, fail_cnt, count_bcd);
    end
    for (int i = 1; i < 8; i++) begin
      digit = 4'd1; digit_valid = 1'b1; clear = i[0];
      @(negedge clk);
      exp_cnt = (i < 4) ? 4'd2 : 4'd1;
      total++; if (locked_out !== 1'b1 || progress !== 4'b0 || count_bcd !== exp_cnt) begin
        bad++; $display("FAIL lockout_hold[%0d]: got lo=%b prog=%b cnt=%0d want lo=1 prog=0000 cnt=%0d", i, locked_out, progress, count_bcd, exp_cnt);
      end
    end
    digit_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    total++; if (locked_out !== 1'b0 || fail_cnt !== 2'd0 || count_bcd !== 4'd0) begin
      bad++; $display("FAIL lockout_expiry: got lo=%b fc=%0d cnt=%0d want lo=0 fc=0 cnt=0", locked_out, fail_cnt, count_bcd);
    end
  endtask

  task automatic test_invalid_and_conflict;
    enter_code(16'h1299);
    @(negedge clk);
    enter_digit(4'd1);
    enter_digit(4'hA);
    total++; if (progress !== 4'b0001) begin
      bad++; $display("FAIL invalid_digit: got %b want 0001", progress);
    end
    enter_digit(4'd2);
    total++; if (progress !== 4'b0011) begin
      bad++; $display("FAIL two_digits: got %b want 0011", progress);
    end
    @(negedge clk);
    digit = 4'd3; digit_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0; clear = 1'b0;
    total++; if (progress !== 4'b0000 || fail_cnt !== 2'd1) begin
      bad++; $display("FAIL clear_with_digit: got prog=%b fc=%0d want prog=0000 fc=1", progress, fail_cnt);
    end
  endtask

  task automatic test_early_relock;
    enter_code(16'h1234);
    @(negedge clk);
    total++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0 || progress !== 4'b1111) begin
      bad++; $display("FAIL relock_open: got unl=%b fc=%0d prog=%b want unl=1 fc=0 prog=1111", unlocked, fail_cnt, progress);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (unlocked !== 1'b0 || count_bcd !== 4'd0 || progress !== 4'b0) begin
      bad++; $display("FAIL relock_clear: got unl=%b cnt=%0d prog=%b want unl=0 cnt=0 prog=0000", unlocked, count_bcd, progress);
    end
  endtask

  task automatic test_reset_mid_open;
    enter_code(16'h1234);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (unlocked !== 1'b0 || count_bcd !== 4'd0) begin
      bad++; $display("FAIL async_reset_drop: got unl=%b cnt=%0d want unl=0 cnt=0", unlocked, count_bcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(16'h1234);
    @(negedge clk);
    total++; if (unlocked !== 1'b1 || count_bcd !== 4'd3) begin
      bad++; $display("FAIL reopen_after_reset: got unl=%b cnt=%0d want unl=1 cnt=3", unlocked, count_bcd);
    end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask

`ifdef COMBO_LOCK_PROG_EN
  task automatic test_prog;
    enter_code(16'h1234);
    @(negedge clk);
    prog_req = 1'b1; @(negedge clk); prog_req = 1'b0;
    total++; if (unlocked !== 1'b0 || progress !== 4'b0) begin
      bad++; $display("FAIL prog_entry: got unl=%b prog=%b want unl=0 prog=0000", unlocked, progress);
    end
    enter_code(16'h9876);
    @(negedge clk);
    total++; if (unlocked !== 1'b0 || progress !== 4'b0) begin
      bad++; $display("FAIL prog_done_idle: got unl=%b prog=%b want unl=0 prog=0000", unlocked, progress);
    end
    enter_code(16'h1234);
    @(negedge clk);
    total++; if (unlocked !== 1'b0 || fail_cnt !== 2'd1) begin
      bad++; $display("FAIL old_code_rejected: got unl=%b fc=%0d want unl=0 fc=1", unlocked, fail_cnt);
    end
    enter_code(16'h9876);
    @(negedge clk);
    total++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
      bad++; $display("FAIL new_code_opens: got unl=%b fc=%0d want unl=1 fc=0", unlocked, fail_cnt);
    end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask
`else
  task automatic test_prog;
    enter_code(16'h1234);
    @(negedge clk);
    prog_req = 1'b1; @(negedge clk); prog_req = 1'b0;
    total++; if (unlocked !== 1'b1 || progress !== 4'b1111) begin
      bad++; $display("FAIL prog_ignored: got unl=%b prog=%b want unl=1 prog=1111", unlocked, progress);
    end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    enter_code(16'h9876);
    @(negedge clk);
    total++; if (unlocked !== 1'b0 || fail_cnt !== 2'd1) begin
      bad++; $display("FAIL fixed_code: got unl=%b fc=%0d want unl=0 fc=1", unlocked, fail_cnt);
    end
    enter_code(16'h1234);
    @(negedge clk);
    total++; if (unlocked !== 1'b1) begin
      bad++; $display("FAIL default_still_opens: got unl=%b want 1", unlocked);
    end
    clear = 1'b1; @(negedge clk); clear = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_correct_code;
    test_three_failures;
    test_invalid_and_conflict;
    test_early_relock;
    test_reset_mid_open;
    test_prog;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
